// File: rtl/buzzer_arbiter_pkg.sv
// Shared encodings and default timing for the piezo buzzer arbiter.
// State, source and tone codes live here so the top and the bench agree on them.
package buzzer_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING_T = 2'd1,
        ST_RING_A = 2'd2,
        ST_CHIME  = 2'd3
    } state_e;

    localparam logic [1:0] SRC_NONE  = 2'b00;
    localparam logic [1:0] SRC_CHIME = 2'b01;
    localparam logic [1:0] SRC_ALARM = 2'b10;
    localparam logic [1:0] SRC_TIMER = 2'b11;

    localparam logic [2:0] TONE_IDLE  = 3'd0;
    localparam logic [2:0] TONE_TIMER = 3'd5;
    localparam logic [2:0] TONE_ALARM = 3'd1;
    localparam logic [2:0] TONE_CHIME = 3'd7;

    localparam int DEF_TICKS_PER_SEC  = 1000;
    localparam int DEF_RING_TIMEOUT_S = 30;
    localparam int DEF_TIMER_ON_MS    = 500;
    localparam int DEF_ALARM_ON_MS    = 250;
    localparam int DEF_CHIME_MS       = 200;

    function automatic logic [1:0] src_of(input state_e s);
        case (s)
            ST_RING_T: return SRC_TIMER;
            ST_RING_A: return SRC_ALARM;
            ST_CHIME:  return SRC_CHIME;
            default:   return SRC_NONE;
        endcase
    endfunction

    function automatic logic [2:0] tone_of(input state_e s);
        case (s)
            ST_RING_T: return TONE_TIMER;
            ST_RING_A: return TONE_ALARM;
            ST_CHIME:  return TONE_CHIME;
            default:   return TONE_IDLE;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/buzzer_arbiter_beep_pattern.sv
// Phase counter shared by all beep patterns; reloaded to zero on every state entry.
// Reports the on/off gate for the phase value that will be current after this edge.
module buzzer_arbiter_beep_pattern #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic         i_clear,
    input  logic [W-1:0] i_on_len,
    input  logic [W-1:0] i_period,
    output logic [W-1:0] o_phase,
    output logic         o_on_nxt
);

    logic [W-1:0] r_phase;
    logic [W-1:0] w_phase_nxt;

    always_comb begin
        w_phase_nxt = r_phase + W'(1);
        if (i_clear || (r_phase >= i_period - W'(1))) begin
            w_phase_nxt = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_phase <= '0;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    assign o_phase  = r_phase;
    assign o_on_nxt = (w_phase_nxt < i_on_len);

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority arbiter sharing one piezo between timer, alarm and hourly chime,
// with per-source beep patterns, user STOP masking and auto-silence after a timeout.
//
// state     | meaning
// ST_IDLE   | piezo off, waiting for an effective request or chime pulse
// ST_RING_T | timer expired, 50% duty pattern of 2*TIMER_ON_MS
// ST_RING_A | alarm match, 50% duty pattern of 2*ALARM_ON_MS
// ST_CHIME  | single continuous beep of CHIME_MS ticks
module buzzer_arbiter
    import buzzer_arbiter_pkg::*;
#(
    parameter int TICKS_PER_SEC  = DEF_TICKS_PER_SEC,
    parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
    parameter int TIMER_ON_MS    = DEF_TIMER_ON_MS,
    parameter int ALARM_ON_MS    = DEF_ALARM_ON_MS,
    parameter int CHIME_MS       = DEF_CHIME_MS
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_req_timer,
    input  logic       i_req_alarm,
    input  logic       i_chime_p,
    input  logic       i_stop_en,
    output logic       o_piezo_en,
    output logic [2:0] o_piezo_tone,
    output logic [1:0] o_src,
    output logic       o_silenced
);

    localparam int RING_TICKS = RING_TIMEOUT_S * TICKS_PER_SEC;
    localparam int CNT_W      = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;
    localparam int PH_MAX     = max3(2 * TIMER_ON_MS, 2 * ALARM_ON_MS, CHIME_MS);
    localparam int PH_W       = $clog2(PH_MAX + 1);

    localparam logic [CNT_W-1:0] RING_LAST  = CNT_W'(RING_TICKS - 1);
    localparam logic [PH_W-1:0]  CHIME_LAST = PH_W'(CHIME_MS - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_ring_cnt;
    logic [CNT_W-1:0]   w_ring_cnt_nxt;
    logic               r_mask_t;
    logic               r_mask_a;
    logic               w_mask_t_nxt;
    logic               w_mask_a_nxt;
    logic               w_set_t;
    logic               w_set_a;
    logic               w_et;
    logic               w_ea;
    logic               w_ringing;
    logic               w_timeout;
    logic               w_clear;
    logic [PH_W-1:0]    w_phase;
    logic [PH_W-1:0]    w_on_len;
    logic [PH_W-1:0]    w_period;
    logic               w_on_nxt;

    assign w_et      = i_req_timer & ~r_mask_t;
    assign w_ea      = i_req_alarm & ~r_mask_a;
    assign w_ringing = (r_state == ST_RING_T) || (r_state == ST_RING_A);
    assign w_timeout = w_ringing && (r_ring_cnt == RING_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_set_t     = 1'b0;
        w_set_a     = 1'b0;
        if (i_stop_en && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_set_t     = (r_state == ST_RING_T);
            w_set_a     = (r_state == ST_RING_A);
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_set_t     = (r_state == ST_RING_T);
            w_set_a     = (r_state == ST_RING_A);
        end else if (w_et) begin
            w_state_nxt = ST_RING_T;
        end else if (w_ea) begin
            w_state_nxt = ST_RING_A;
        end else if (w_ringing) begin
            w_state_nxt = ST_IDLE;
        end else if ((r_state == ST_IDLE) && i_chime_p) begin
            w_state_nxt = ST_CHIME;
        end else if ((r_state == ST_CHIME) && (w_phase == CHIME_LAST)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign w_clear = (w_state_nxt != r_state);

    // A released request always clears its mask, even on an edge that would set it.
    assign w_mask_t_nxt = i_req_timer & (r_mask_t | w_set_t);
    assign w_mask_a_nxt = i_req_alarm & (r_mask_a | w_set_a);

    always_comb begin
        w_ring_cnt_nxt = r_ring_cnt + CNT_W'(1);
        if (w_clear || !w_ringing) begin
            w_ring_cnt_nxt = '0;
        end
    end

    always_comb begin
        w_on_len = '0;
        w_period = PH_W'(1);
        case (w_state_nxt)
            ST_RING_T: begin
                w_on_len = PH_W'(TIMER_ON_MS);
                w_period = PH_W'(2 * TIMER_ON_MS);
            end
            ST_RING_A: begin
                w_on_len = PH_W'(ALARM_ON_MS);
                w_period = PH_W'(2 * ALARM_ON_MS);
            end
            ST_CHIME: begin
                w_on_len = PH_W'(CHIME_MS);
                w_period = PH_W'(CHIME_MS);
            end
            default: begin
                w_on_len = '0;
                w_period = PH_W'(1);
            end
        endcase
    end

    buzzer_arbiter_beep_pattern #(
        .W (PH_W)
    ) u_beep_pattern (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_clear  (w_clear),
        .i_on_len (w_on_len),
        .i_period (w_period),
        .o_phase  (w_phase),
        .o_on_nxt (w_on_nxt)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state      <= ST_IDLE;
            r_ring_cnt   <= '0;
            r_mask_t     <= 1'b0;
            r_mask_a     <= 1'b0;
            o_piezo_en   <= 1'b0;
            o_piezo_tone <= TONE_IDLE;
            o_src        <= SRC_NONE;
            o_silenced   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ring_cnt   <= w_ring_cnt_nxt;
            r_mask_t     <= w_mask_t_nxt;
            r_mask_a     <= w_mask_a_nxt;
            o_piezo_en   <= (w_state_nxt != ST_IDLE) && w_on_nxt;
            o_piezo_tone <= tone_of(w_state_nxt);
            o_src        <= src_of(w_state_nxt);
            o_silenced   <= w_mask_t_nxt | w_mask_a_nxt;
        end
    end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Self-checking bench for buzzer_arbiter using small timing parameters.
// Reference model tracks the active source and cycles since it became active.
module tb_buzzer_arbiter;

    localparam int TPS     = 10;
    localparam int TOUT_S  = 2;
    localparam int T_ON    = 3;
    localparam int A_ON    = 2;
    localparam int CH_MS   = 4;
    localparam int RING_N  = TPS * TOUT_S;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_timer = 1'b0;
    logic       req_alarm = 1'b0;
    logic       chime_p = 1'b0;
    logic       stop_en = 1'b0;
    logic       piezo_en;
    logic [2:0] piezo_tone;
    logic [1:0] src;
    logic       silenced;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // model: source id 0 none, 1 chime, 2 alarm, 3 timer
    int m_src = 0;
    int m_age = 0;
    bit m_mask_t = 1'b0;
    bit m_mask_a = 1'b0;

    buzzer_arbiter #(
        .TICKS_PER_SEC  (TPS),
        .RING_TIMEOUT_S (TOUT_S),
        .TIMER_ON_MS    (T_ON),
        .ALARM_ON_MS    (A_ON),
        .CHIME_MS       (CH_MS)
    ) dut (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_req_timer  (req_timer),
        .i_req_alarm  (req_alarm),
        .i_chime_p    (chime_p),
        .i_stop_en    (stop_en),
        .o_piezo_en   (piezo_en),
        .o_piezo_tone (piezo_tone),
        .o_src        (src),
        .o_silenced   (silenced)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_src = 0;
        m_age = 0;
        m_mask_t = 1'b0;
        m_mask_a = 1'b0;
    endtask

    task automatic model_step();
        bit et, ea, set_t, set_a;
        int nsrc;
        et = req_timer && !m_mask_t;
        ea = req_alarm && !m_mask_a;
        set_t = 1'b0;
        set_a = 1'b0;
        nsrc = m_src;
        if (stop_en && m_src != 0) begin
            set_t = (m_src == 3);
            set_a = (m_src == 2);
            nsrc = 0;
        end else if (m_src >= 2 && m_age == RING_N - 1) begin
            set_t = (m_src == 3);
            set_a = (m_src == 2);
            nsrc = 0;
        end else if (et) nsrc = 3;
        else if (ea) nsrc = 2;
        else if (m_src >= 2) nsrc = 0;
        else if (m_src == 0 && chime_p) nsrc = 1;
        else if (m_src == 1 && m_age == CH_MS - 1) nsrc = 0;
        m_age = (nsrc != m_src) ? 0 : m_age + 1;
        m_src = nsrc;
        m_mask_t = req_timer && (m_mask_t || set_t);
        m_mask_a = req_alarm && (m_mask_a || set_a);
    endtask

    function automatic logic [6:0] exp_vec();
        logic en;
        logic [2:0] tone;
        logic [1:0] s;
        case (m_src)
            3: begin en = (m_age % (2 * T_ON)) < T_ON; tone = 3'd5; s = 2'b11; end
            2: begin en = (m_age % (2 * A_ON)) < A_ON; tone = 3'd1; s = 2'b10; end
            1: begin en = 1'b1; tone = 3'd7; s = 2'b01; end
            default: begin en = 1'b0; tone = 3'd0; s = 2'b00; end
        endcase
        return {en, tone, s, m_mask_t | m_mask_a};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {piezo_en, piezo_tone, src, silenced};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        checks++;
        if (dut_vec() !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 7'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_timer_pattern();
        req_timer = 1'b1;
        for (int i = 0; i < RING_N + 4; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL timer_pattern cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (i == 0 || i == 3 || i == RING_N) begin
                checks++;
                if ({piezo_en, src, silenced} !== ((i == 0) ? 4'b1110 : (i == 3) ? 4'b0110 : 4'b0001)) begin
                    errors++;
                    $display("FAIL timer_landmark i=%0d got=%b", i, {piezo_en, src, silenced});
                end
            end
        end
        req_timer = 1'b0;
        step();
        checks++;
        if (silenced !== 1'b0) begin
            errors++;
            $display("FAIL timer_unmask got=%b exp=0", silenced);
        end
    endtask

    task automatic test_alarm_preempt();
        req_alarm = 1'b1;
        for (int i = 0; i < 7 + 6 + 25; i++) begin
            if (i == 7) req_timer = 1'b1;
            if (i == 13) req_timer = 1'b0;
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL alarm_preempt cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (i == 7 || i == 13) begin
                checks++;
                if ({piezo_en, src} !== ((i == 7) ? 3'b111 : 3'b110)) begin
                    errors++;
                    $display("FAIL preempt_switch i=%0d got=%b", i, {piezo_en, src});
                end
            end
        end
        req_alarm = 1'b0;
        step();
        step();
    endtask

    task automatic test_chime();
        int en_cnt;
        en_cnt = 0;
        chime_p = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chime_p = 1'b0;
            if (piezo_en === 1'b1 && src === 2'b01) en_cnt++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL chime cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (en_cnt != CH_MS) begin
            errors++;
            $display("FAIL chime_length got=%0d exp=%0d", en_cnt, CH_MS);
        end
        req_alarm = 1'b1;
        step();
        step();
        chime_p = 1'b1;
        step();
        chime_p = 1'b0;
        req_alarm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (src !== 2'b00 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL chime_dropped cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_stop();
        req_alarm = 1'b1;
        step();
        step();
        stop_en = 1'b1;
        step();
        stop_en = 1'b0;
        checks++;
        if ({src, silenced} !== 3'b001) begin
            errors++;
            $display("FAIL stop_alarm got=%b exp=001", {src, silenced});
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 4) req_alarm = 1'b0;
            if (i == 5) req_alarm = 1'b1;
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stop_mask cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (src !== 2'b10) begin
            errors++;
            $display("FAIL stop_rering got=%b exp=10", src);
        end
    endtask

    task automatic test_stop_same_edge();
        stop_en = 1'b1;
        req_timer = 1'b1;
        step();
        stop_en = 1'b0;
        checks++;
        if (src !== 2'b00) begin
            errors++;
            $display("FAIL stop_wins got=%b exp=00", src);
        end
        step();
        checks++;
        if ({piezo_en, src} !== 3'b111) begin
            errors++;
            $display("FAIL timer_after_stop got=%b exp=111", {piezo_en, src});
        end
        req_timer = 1'b0;
        req_alarm = 1'b0;
        step();
        step();
    endtask

    task automatic test_async_reset();
        req_timer = 1'b1;
        for (int i = 0; i < RING_N + 3; i++) step();
        checks++;
        if (silenced !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_mask got=%b exp=1", silenced);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 7'd0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", dut_vec(), 7'd0);
        end
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        step();
        checks++;
        if ({piezo_en, piezo_tone, src, silenced} !== 7'b1101110) begin
            errors++;
            $display("FAIL ring_after_reset got=%b exp=1101110", dut_vec());
        end
        req_timer = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) req_timer = ~req_timer;
            if ($urandom_range(0, 19) == 0) req_alarm = ~req_alarm;
            chime_p = ($urandom_range(0, 14) == 0);
            stop_en = ($urandom_range(0, 29) == 0);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        chime_p = 1'b0;
        stop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        step();
        test_timer_pattern();
        test_alarm_preempt();
        test_chime();
        test_stop();
        test_stop_same_edge();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
- Shares the single piezo output between three requesters:
  - timer expiry (S from the timer block, a level),
  - the alarm-match level from the alarm block,
  - the hourly-chime pulse from the clock block.
- Applies fixed priority, per-source beep patterns, user STOP, and an auto-silence timeout.
- Sits between the time-keeping blocks and the piezo tone driver, clocked by the 1 kHz system clock.

Parameters:
- TICKS_PER_SEC, 1000, clock ticks per second.
- RING_TIMEOUT_S, 30, seconds of continuous ringing before auto-silence.
- TIMER_ON_MS, 500, timer pattern on-time (off-time equal, period 2*TIMER_ON_MS).
- ALARM_ON_MS, 250, alarm pattern on-time (off-time equal).
- CHIME_MS, 200, single chime beep length.

Ports:
- CLK  in  1  system clock, 1 kHz.
- RESETN  in  1  asynchronous active-low reset.
- REQ_TIMER  in  1  timer-expired level.
- REQ_ALARM  in  1  alarm-match level.
- CHIME_P  in  1  single-cycle hourly-chime pulse.
- STOP_EN  in  1  single-cycle STOP key pulse, already one-shot upstream.
- PIEZO_EN  out  1  piezo drive gate.
- PIEZO_TONE  out  3  tone select: 0 idle, 5 timer, 1 alarm, 7 chime.
- SRC  out  2  active source: 00 none, 01 chime, 10 alarm, 11 timer.
- SILENCED  out  1  high while any source is masked.

Behaviour:
- Reset (async, RESETN=0): state IDLE; all counters 0; masks 0. Outputs all 0: PIEZO_EN, PIEZO_TONE, SRC, SILENCED.
- All outputs are registered. Each is a function of the next state and next phase, so a request sampled at edge k gives PIEZO_EN=1 after edge k (1-cycle latency).
- Effective requests:
  - et = REQ_TIMER & ~mask_t
  - ea = REQ_ALARM & ~mask_a
- Mask clearing: every cycle, mask_t clears when REQ_TIMER=0 and mask_a clears when REQ_ALARM=0. A source stays silent until it deasserts and reasserts.
- States: IDLE, RING_T, RING_A, CHIME.
- Transition priority per edge, evaluated in this order:
  1. STOP_EN in RING_T/RING_A: set that source's mask, go IDLE. In CHIME: go IDLE. In IDLE: ignored.
  2. Timeout in RING_x: ring_cnt == RING_TIMEOUT_S*TICKS_PER_SEC-1 → set mask_x, go IDLE.
  3. et=1 and state≠RING_T → RING_T (preempts alarm/chime). Phase and ring_cnt reset to 0.
  4. et=0, ea=1, state ∈ {IDLE, CHIME, RING_T} → RING_A. Phase and ring_cnt reset to 0.
  5. In RING_x, source's effective request drops → go to the next lower effective request, else IDLE.
  6. CHIME_P=1 in IDLE with et=ea=0 → CHIME, phase 0.
     - CHIME_P in any other state is dropped (not queued).
     - CHIME ends after CHIME_MS cycles → IDLE.
- Phase counter in RING_T wraps at 2*TIMER_ON_MS-1; in RING_A at 2*ALARM_ON_MS-1.
- PIEZO_EN:
  - 1 while phase < ON_MS;
  - 1 for the whole of CHIME;
  - 0 in IDLE.
- PIEZO_TONE and SRC follow the state and are constant across on/off phases.
- ring_cnt saturates only through the timeout transition. Width is ceil(log2(RING_TIMEOUT_S*TICKS_PER_SEC)), 15 bits for the defaults.
- SILENCED = mask_t | mask_a (registered).
- STOP and a new higher request on the same edge: STOP wins for that edge; the new request is taken on the next edge.

Decomposition:
- Shared package: state encoding, SRC codes, tone codes, default timing constants.
- One natural sub-module, beep_pattern:
  - inputs: clear, on_len, period;
  - phase counter plus on/off compare;
  - instantiated once and reloaded on each state entry.

Test Plan (small parameters for sim: TICKS_PER_SEC=10, RING_TIMEOUT_S=2, TIMER_ON_MS=3, ALARM_ON_MS=2, CHIME_MS=4):
- REQ_TIMER rises at edge 5 → SRC=11, PIEZO_TONE=5 from edge 5. PIEZO_EN pattern 1,1,1,0,0,0 repeating. At edge 25 SRC=00 and SILENCED=1. SILENCED=0 one cycle after REQ_TIMER drops.
- REQ_ALARM high, then REQ_TIMER high 7 cycles later → SRC 10→11 with phase restart. Drop REQ_TIMER → SRC returns to 10 with fresh timeout count.
- CHIME_P in IDLE → PIEZO_EN=1 and SRC=01 for exactly 4 cycles. CHIME_P during RING_A → ignored, no chime afterwards.
- STOP_EN during RING_A → IDLE next edge, alarm masked while REQ_ALARM stays high. Lower REQ_ALARM and raise it again → rings again.
- STOP_EN on the same edge REQ_TIMER rises while in RING_A → IDLE for one cycle, then RING_T.
- RESETN pulsed low mid-RING_T → all outputs 0 immediately (async); masks cleared. Ringing restarts after release if REQ_TIMER is still high.
